led_dec: RTL and testbench

//  Iterative LED-64 block-cipher decryption core; inverse of the LED-64 encryption core.

---
 rtl/led_dec.sv | 102 ++++++++++
 tb/tb_led_dec.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_dec.sv
// led_dec: iterative LED-64 decryption core, one inverse round per clock with start/busy/done handshake
module led_dec #(
  parameter int         ROUNDS = 32,
  parameter logic [7:0] KS     = 8'h40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] ct_i,
  input  logic [63:0] key_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] pt_o
);
  localparam logic [63:0] ISB     = 64'h5EF8_C12D_B463_079A;
  localparam logic [63:0] IMC     = 64'hCCD4_3845_762E_D99D;
  localparam logic [4:0]  R_LAST  = 5'(ROUNDS - 1);
  // round constant of round 31; the LFSR is stepped backwards from here
  localparam logic [5:0]  RC_LAST = 6'h38;
  typedef enum logic {IDLE, RUN} st_t;
  st_t         st_q, st_d;
  logic [63:0] state_q, state_d, key_q, key_d, pt_q, pt_d;
  logic [4:0]  r_q, r_d;
  logic [5:0]  rc_q, rc_d;
  logic        done_q, done_d;
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int k = 0; k < 4; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [63:0] inv_round(input logic [63:0] x, input logic [5:0] rc);
    logic [3:0]  s [16];
    logic [3:0]  m [16];
    logic [3:0]  v, c;
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) s[i] = x[4*(15-i) +: 4];
    for (int i = 0; i < 16; i++) begin
      m[i] = 4'h0;
      for (int k = 0; k < 4; k++) m[i] ^= gmul(IMC[4*(15-(i/4*4+k)) +: 4], s[k*4+i%4]);
    end
    for (int i = 0; i < 16; i++) begin
      v = m[i/4*4 + (i%4 - i/4 + 4) % 4];
      c = (i%4 == 0) ? ((i < 8 ? KS[7:4] : KS[3:0]) ^ 4'(i/4)) :
          (i%4 == 1) ? {1'b0, ((i/4)%2 == 1) ? rc[2:0] : rc[5:3]} : 4'h0;
      y[4*(15-i) +: 4] = ISB[4*(15-int'(v)) +: 4] ^ c;
    end
    return y;
  endfunction
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    r_d     = r_q;
    rc_d    = rc_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    if (st_q == IDLE && start_i) begin
      st_d    = RUN;
      state_d = ct_i ^ key_i;
      key_d   = key_i;
      r_d     = R_LAST;
      rc_d    = RC_LAST;
    end else if (st_q == RUN) begin
      state_d = inv_round(state_q, rc_q) ^ (r_q[1:0] == 2'd0 ? key_q : 64'h0);
      r_d     = r_q - 5'd1;
      rc_d    = {rc_q[0] ^ rc_q[5] ^ 1'b1, rc_q[5:1]};
      if (r_q == 5'd0) begin
        st_d   = IDLE;
        pt_d   = state_d;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      r_q     <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      r_q     <= r_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = (st_q == RUN);
  assign done_o = done_q;
  assign pt_o   = pt_q;
endmodule

// File: tb/tb_led_dec.sv
// tb_led_dec: directed and loopback checks of led_dec against known vectors and an LED-64 encryption model
module tb_led_dec;
  localparam logic [63:0] V1C = 64'h39c2401003a0c798;
  localparam logic [63:0] V2C = 64'ha003551e3893fc58;
  localparam logic [63:0] V2K = 64'h0123456789abcdef;
  localparam logic [63:0] SB  = 64'hC56B_90AD_3EF8_4712;
  localparam logic [63:0] MC  = 64'h4122_8656_BEA9_22FB;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] ct = '0, key = '0;
  logic        busy, done;
  logic [63:0] pt;
  int          vecs = 0, errs = 0, dcnt = 0;
  led_dec dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ct_i(ct), .key_i(key),
    .busy_o(busy), .done_o(done), .pt_o(pt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) dcnt++;
  function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p ^= x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [63:0] led_enc(input logic [63:0] p, input logic [63:0] kk);
    logic [3:0]  s [16];
    logic [3:0]  t [16];
    logic [3:0]  acc;
    logic [5:0]  rc;
    logic [63:0] x;
    x  = p;
    rc = 6'h0;
    for (int st = 0; st < 8; st++) begin
      x ^= kk;
      for (int rr = 0; rr < 4; rr++) begin
        rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
        for (int i = 0; i < 16; i++) s[i] = x[4*(15-i) +: 4];
        s[0]  ^= 4'h4;
        s[4]  ^= 4'h5;
        s[8]  ^= 4'h2;
        s[12] ^= 4'h3;
        s[1]  ^= {1'b0, rc[5:3]};
        s[5]  ^= {1'b0, rc[2:0]};
        s[9]  ^= {1'b0, rc[5:3]};
        s[13] ^= {1'b0, rc[2:0]};
        for (int i = 0; i < 16; i++) s[i] = SB[4*(15-int'(s[i])) +: 4];
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) t[4*i+j] = s[4*i + (j+i)%4];
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            acc = 4'h0;
            for (int k = 0; k < 4; k++) acc ^= gm(MC[4*(15-(4*i+k)) +: 4], t[4*k+j]);
            x[4*(15-(4*i+j)) +: 4] = acc;
          end
      end
    end
    return x ^ kk;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [63:0] c_in, input logic [63:0] k_in, output int n);
    @(negedge clk);
    ct    = c_in;
    key   = k_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int          n, d0;
    logic [63:0] p, kk;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pt", pt, 64'h0);
    rst = 1'b0;
    run(V1C, 64'h0, n);
    chk("t1_lat", 64'(n), 64'd33);
    chk("t1_pt", pt, 64'h0);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    run(V2C, V2K, n);
    chk("t2_lat", 64'(n), 64'd33);
    chk("t2_pt", pt, V2K);
    @(negedge clk);
    ct    = V1C;
    key   = 64'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_busy", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    ct    = V2C;
    key   = V2K;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 11;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_lat", 64'(n), 64'd33);
    chk("t3_pt", pt, 64'h0);
    #1 d0 = dcnt;
    repeat (40) @(negedge clk);
    #1 chk("t3_single_done", 64'(dcnt), 64'(d0));
    @(negedge clk);
    ct    = V1C;
    key   = 64'h0;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    chk("t5_busy_a", 64'(busy), 64'd1);
    ct  = V2C;
    key = V2K;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_lat_a", 64'(n), 64'd33);
    chk("t5_pt_a", pt, 64'h0);
    @(negedge clk);
    n = 1;
    chk("t5_busy_b", 64'(busy), 64'd1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("t5_lat_b", 64'(n), 64'd33);
    chk("t5_pt_b", pt, V2K);
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);
    ct    = V1C;
    key   = 64'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_pt", pt, 64'h0);
    d0 = dcnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1 chk("t4_no_done", 64'(dcnt), 64'(d0));
    run(V2C, V2K, n);
    chk("t4_lat", 64'(n), 64'd33);
    chk("t4_pt_after", pt, V2K);
    for (int i = 0; i < 1000; i++) begin
      p  = {$urandom, $urandom};
      kk = {$urandom, $urandom};
      run(led_enc(p, kk), kk, n);
      chk("loop_lat", 64'(n), 64'd33);
      chk("loop_pt", pt, p);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
